// File: rtl/axis_frame_source_if.sv
// AXI-Stream link carrying test frames from a generator to a downstream slave.
// The master drives the payload and TVALID; the slave drives TREADY.
interface axis_frame_source_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    TVALID;
  logic                    TREADY;
  logic [DATA_WIDTH-1:0]   TDATA;
  logic [DATA_WIDTH/8-1:0] TSTRB;
  logic                    TLAST;
  logic                    TUSER;

  modport master (
    output TVALID,
    output TDATA,
    output TSTRB,
    output TLAST,
    output TUSER,
    input  TREADY
  );

  modport slave (
    input  TVALID,
    input  TDATA,
    input  TSTRB,
    input  TLAST,
    input  TUSER,
    output TREADY
  );
endinterface

// File: rtl/axis_frame_source.sv
// AXI-Stream frame generator: on start, emits frame_len beats counting up from seed,
// TUSER on the first beat, TLAST on the last, then pulses done and counts the frame.
module axis_frame_source #(
  parameter int DATA_WIDTH = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  frame_len,
  input  logic [DATA_WIDTH-1:0] seed,
  axis_frame_source_if.master   m_axis,
  output logic                  busy,
  output logic                  done,
  output logic                  len_err,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_next;

  logic [LEN_WIDTH-1:0]    r_len;
  logic [DATA_WIDTH-1:0]   r_seed;
  logic [LEN_WIDTH-1:0]    r_beat_idx;
  logic                    r_tvalid;
  logic [DATA_WIDTH-1:0]   r_tdata;
  logic [DATA_WIDTH/8-1:0] r_tstrb;
  logic                    r_tlast;
  logic                    r_tuser;
  logic                    r_len_err;
  logic [15:0]             r_frame_cnt;

  logic                    w_idle;
  logic                    w_start_ok;
  logic                    w_start_zero;
  logic                    w_hs;
  logic [LEN_WIDTH-1:0]    w_idx_next;
  logic                    w_last_next;

  assign w_idle       = (r_state == S_IDLE);
  assign w_start_ok   = start & w_idle & (frame_len != '0);
  assign w_start_zero = start & w_idle & (frame_len == '0);
  assign w_hs         = r_tvalid & m_axis.TREADY;
  // beat_idx never exceeds len-1 <= 2**LEN_WIDTH-2, so this increment cannot wrap
  assign w_idx_next   = r_beat_idx + LEN_WIDTH'(1);
  assign w_last_next  = (w_idx_next == (r_len - LEN_WIDTH'(1)));

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: if (w_start_ok)         w_state_next = S_SEND;
      S_SEND: if (w_hs && r_tlast)    w_state_next = S_DONE;
      S_DONE:                         w_state_next = S_IDLE;
      default:                        w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state != S_IDLE);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      r_len       <= '0;
      r_seed      <= '0;
      r_beat_idx  <= '0;
      r_tvalid    <= 1'b0;
      r_tdata     <= '0;
      r_tstrb     <= '0;
      r_tlast     <= 1'b0;
      r_tuser     <= 1'b0;
      r_len_err   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_len_err <= w_start_zero;
      if (w_start_ok) begin
        r_len      <= frame_len;
        r_seed     <= seed;
        r_beat_idx <= '0;
        r_tvalid   <= 1'b1;
        r_tdata    <= seed;
        r_tstrb    <= '1;
        r_tlast    <= (frame_len == LEN_WIDTH'(1));
        r_tuser    <= 1'b1;
      end else if (w_hs) begin
        if (r_tlast) begin
          r_tvalid <= 1'b0;
          r_tstrb  <= '0;
          r_tlast  <= 1'b0;
          r_tuser  <= 1'b0;
        end else begin
          r_beat_idx <= w_idx_next;
          r_tdata    <= r_seed + DATA_WIDTH'(w_idx_next);
          r_tlast    <= w_last_next;
          r_tuser    <= 1'b0;
        end
      end
      if (r_state == S_DONE) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  assign m_axis.TVALID = r_tvalid;
  assign m_axis.TDATA  = r_tdata;
  assign m_axis.TSTRB  = r_tstrb;
  assign m_axis.TLAST  = r_tlast;
  assign m_axis.TUSER  = r_tuser;
  assign len_err       = r_len_err;
  assign frame_cnt     = r_frame_cnt;

endmodule

// File: tb/tb_axis_frame_source.sv
// Directed bench for axis_frame_source: a queue of expected beats is filled when a frame
// is requested and drained on every observed handshake.
module tb_axis_frame_source;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [15:0] frame_len = '0;
  logic [31:0] seed = '0;
  logic        busy, done, len_err;
  logic [15:0] frame_cnt;

  axis_frame_source_if #(.DATA_WIDTH(32)) axis ();

  axis_frame_source #(.DATA_WIDTH(32), .LEN_WIDTH(16)) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .start     (start),
    .frame_len (frame_len),
    .seed      (seed),
    .m_axis    (axis),
    .busy      (busy),
    .done      (done),
    .len_err   (len_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] d;
    logic        l;
    logic        u;
  } beat_t;

  beat_t       exp_q[$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          hs_cnt = 0;
  logic        have_held = 1'b0;
  logic [31:0] held_d;
  logic        held_l, held_u;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_frame(input int len, input logic [31:0] sd);
    for (int i = 0; i < len; i++) begin
      beat_t b;
      b.d = sd + 32'(i);
      b.l = (i == len - 1);
      b.u = (i == 0);
      exp_q.push_back(b);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then judge the beat that the
  // next rising edge will transfer (or confirm a stalled beat is held).
  task automatic cyc(input logic rdy, input logic st, input logic [15:0] len, input logic [31:0] sd);
    beat_t e;
    @(negedge clk);
    axis.TREADY = rdy;
    start       = st;
    frame_len   = len;
    seed        = sd;
    if (have_held) begin
      chk("stall_tvalid", axis.TVALID, 1'b1);
      chk("stall_tdata", axis.TDATA, held_d);
      chk("stall_tlast", axis.TLAST, held_l);
      chk("stall_tuser", axis.TUSER, held_u);
    end
    if (axis.TVALID && rdy) begin
      hs_cnt++;
      have_held = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 1'b1, 1'b0);
      end else begin
        e = exp_q.pop_front();
        chk("tdata", axis.TDATA, e.d);
        chk("tlast", axis.TLAST, e.l);
        chk("tuser", axis.TUSER, e.u);
        chk("tstrb", axis.TSTRB, 4'hF);
      end
    end else if (axis.TVALID) begin
      have_held = 1'b1;
      held_d    = axis.TDATA;
      held_l    = axis.TLAST;
      held_u    = axis.TUSER;
    end else begin
      have_held = 1'b0;
    end
  endtask

  task automatic wait_done(input int budget, input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      cyc(1'b1, 1'b0, 16'd0, 32'd0);
      if (done) seen = 1'b1;
    end
    chk(tag, seen, 1'b1);
  endtask

  initial begin
    int   hs0;
    logic seen;

    // Reset values
    axis.TREADY = 1'b0;
    #12;
    chk("rst_tvalid", axis.TVALID, 1'b0);
    chk("rst_tlast", axis.TLAST, 1'b0);
    chk("rst_tuser", axis.TUSER, 1'b0);
    chk("rst_tdata", axis.TDATA, 32'd0);
    chk("rst_tstrb", axis.TSTRB, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_len_err", len_err, 1'b0);
    chk("rst_frame_cnt", frame_cnt, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // 1: four beats from 0x10, TREADY high, done five cycles after start
    push_frame(4, 32'h10);
    cyc(1'b1, 1'b1, 16'd4, 32'h10);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'd0, 32'd0);
      chk("t1_busy", busy, 1'b1);
    end
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t1_done_at_n5", done, 1'b1);
    chk("t1_tvalid_dropped", axis.TVALID, 1'b0);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t1_done_one_cycle", done, 1'b0);
    chk("t1_frame_cnt", frame_cnt, 16'd1);
    chk("t1_idle", busy, 1'b0);

    // 2: data wraps past all-ones while TREADY stalls in a 1,0,0 pattern
    push_frame(3, 32'hFFFF_FFFE);
    hs0 = hs_cnt;
    seen = 1'b0;
    cyc(1'b0, 1'b1, 16'd3, 32'hFFFF_FFFE);
    for (int i = 0; i < 40 && !seen; i++) begin
      cyc((i % 3) == 0, 1'b0, 16'd0, 32'd0);
      if (done) seen = 1'b1;
    end
    chk("t2_done_seen", seen, 1'b1);
    chk("t2_handshakes", 32'(hs_cnt - hs0), 32'd3);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t2_frame_cnt", frame_cnt, 16'd2);

    // 3: zero-length request only raises len_err
    cyc(1'b1, 1'b1, 16'd0, 32'h55);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t3_len_err", len_err, 1'b1);
    chk("t3_tvalid", axis.TVALID, 1'b0);
    chk("t3_busy", busy, 1'b0);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t3_len_err_pulse", len_err, 1'b0);
    chk("t3_tvalid_after", axis.TVALID, 1'b0);
    chk("t3_frame_cnt", frame_cnt, 16'd2);

    // 4: single-beat frame carries both TUSER and TLAST
    push_frame(1, 32'h0000_ABCD);
    cyc(1'b1, 1'b1, 16'd1, 32'h0000_ABCD);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t4_done", done, 1'b1);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t4_frame_cnt", frame_cnt, 16'd3);

    // 5: a start mid-frame with other len/seed is ignored, not queued
    push_frame(5, 32'h100);
    cyc(1'b1, 1'b1, 16'd5, 32'h100);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    cyc(1'b1, 1'b1, 16'd2, 32'h999);
    wait_done(20, "t5_done_seen");
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 1'b0, 16'd0, 32'd0);
      chk("t5_no_queued_frame", axis.TVALID, 1'b0);
    end
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t5_frame_cnt", frame_cnt, 16'd4);

    // 6: reset during beat 2 of an 8-beat frame, then a fresh full frame
    push_frame(8, 32'h2000);
    cyc(1'b1, 1'b1, 16'd8, 32'h2000);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    @(posedge clk);
    #2;
    chk("t6_beat2_valid", axis.TVALID, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_async_tvalid", axis.TVALID, 1'b0);
    chk("t6_async_tlast", axis.TLAST, 1'b0);
    chk("t6_async_frame_cnt", frame_cnt, 16'd0);
    chk("t6_async_busy", busy, 1'b0);
    exp_q.delete();
    have_held = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    push_frame(8, 32'h3000);
    cyc(1'b1, 1'b1, 16'd8, 32'h3000);
    wait_done(20, "t6_done_seen");
    cyc(1'b1, 1'b0, 16'd0, 32'd0);
    chk("t6_frame_cnt", frame_cnt, 16'd1);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
